// File: rtl/fx3_stream_reader_if.sv
// Buffer-side and FX3-side signal bundle for fx3_stream_reader.
// The master modport belongs to the reader. The slave modport is for the buffer/FX3 side.
interface fx3_stream_reader_if;
  logic        collectData;
  logic        dataAvailable;
  logic [15:0] bufferData;
  logic        isReading;
  logic        fx3Ready;
  logic [15:0] fx3Data;
  logic        fx3Write;
  logic        transferActive;
  logic [15:0] blockCount;

  modport master (
    input  collectData, dataAvailable, bufferData, fx3Ready,
    output isReading, fx3Data, fx3Write, transferActive, blockCount
  );

  modport slave (
    output collectData, dataAvailable, bufferData, fx3Ready,
    input  isReading, fx3Data, fx3Write, transferActive, blockCount
  );
endinterface

// File: rtl/fx3_stream_reader.sv
// Drains one BLOCK_WORDS block from the ping-pong buffer into the FX3 slave FIFO, throttled by fx3Ready.
// Defining FX3_TEST_PATTERN_EN replaces buffer data with a 10-bit running count. Buffer reads continue in that mode.
module fx3_stream_reader #(
  parameter int BLOCK_WORDS = 8192,
  parameter int COUNT_WIDTH = 14
) (
  input logic                 readClock,
  input logic                 reset,
  fx3_stream_reader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    STREAM  = 3'd2,
    DRAIN   = 3'd3,
    RELEASE = 3'd4
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(BLOCK_WORDS - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] read_count_q, read_count_d;
  logic                   rd_pend_q, rd_pend_d;
  logic [15:0]            fx3_data_q, fx3_data_d;
  logic                   fx3_write_q, fx3_write_d;
  logic [15:0]            block_count_q, block_count_d;
  logic                   transfer_active_q, transfer_active_d;
  logic                   is_reading;
`ifdef FX3_TEST_PATTERN_EN
  logic [9:0]             pattern_count_q, pattern_count_d;
`endif

  always_comb begin
    state_d       = state_q;
    read_count_d  = read_count_q;
    block_count_d = block_count_q;
    is_reading    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.collectData) state_d = ARM;
        else                 state_d = IDLE;
      end
      ARM: begin
        if (bus.dataAvailable && bus.fx3Ready) state_d = STREAM;
        else                                   state_d = ARM;
      end
      STREAM: begin
        is_reading = bus.fx3Ready;
        // The read that issues the last word of the block also ends STREAM.
        if (is_reading) begin
          if (read_count_q == LAST_COUNT) begin
            read_count_d = '0;
            state_d      = DRAIN;
          end else begin
            read_count_d = read_count_q + COUNT_ONE;
          end
        end else begin
          read_count_d = read_count_q;
        end
      end
      DRAIN: begin
        // With rd_pend clear, the last word leaves fx3_write on this edge.
        if (!rd_pend_q) begin
          block_count_d = block_count_q + 16'd1;
          state_d       = RELEASE;
        end else begin
          state_d = DRAIN;
        end
      end
      RELEASE: begin
        // Hold until the buffer drops its flag so a stale dataAvailable cannot restart us.
        if (!bus.dataAvailable) state_d = bus.collectData ? ARM : IDLE;
        else                    state_d = RELEASE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rd_pend_d         = is_reading;
    fx3_write_d       = rd_pend_q;
    transfer_active_d = (state_d == ARM) || (state_d == STREAM) || (state_d == DRAIN);

`ifdef FX3_TEST_PATTERN_EN
    if (rd_pend_q) begin
      fx3_data_d      = {6'b000000, pattern_count_q};
      pattern_count_d = pattern_count_q + 10'd1;
    end else begin
      fx3_data_d      = fx3_data_q;
      pattern_count_d = pattern_count_q;
    end
`else
    if (rd_pend_q) fx3_data_d = bus.bufferData;
    else           fx3_data_d = fx3_data_q;
`endif
  end

  always_ff @(posedge readClock) begin
    if (reset) begin
      state_q           <= IDLE;
      read_count_q      <= '0;
      rd_pend_q         <= 1'b0;
      fx3_data_q        <= 16'd0;
      fx3_write_q       <= 1'b0;
      block_count_q     <= 16'd0;
      transfer_active_q <= 1'b0;
`ifdef FX3_TEST_PATTERN_EN
      pattern_count_q   <= 10'd0;
`endif
    end else begin
      state_q           <= state_d;
      read_count_q      <= read_count_d;
      rd_pend_q         <= rd_pend_d;
      fx3_data_q        <= fx3_data_d;
      fx3_write_q       <= fx3_write_d;
      block_count_q     <= block_count_d;
      transfer_active_q <= transfer_active_d;
`ifdef FX3_TEST_PATTERN_EN
      pattern_count_q   <= pattern_count_d;
`endif
    end
  end

  assign bus.isReading      = is_reading;
  assign bus.fx3Data        = fx3_data_q;
  assign bus.fx3Write       = fx3_write_q;
  assign bus.transferActive = transfer_active_q;
  assign bus.blockCount     = block_count_q;

endmodule

// File: tb/tb_fx3_stream_reader.sv
// Directed bench for fx3_stream_reader: a single-cycle control table plus multi-block sequences.
// A buffer model serves reads, and a monitor checks every FX3 write against the expected word.
module tb_fx3_stream_reader;

  localparam int BW = 8192;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fx3_stream_reader_if bus ();

  fx3_stream_reader #(.BLOCK_WORDS(BW), .COUNT_WIDTH(14)) dut (
    .readClock (clk),
    .reset     (rst),
    .bus       (bus)
  );

  int tests = 0;
  int fails = 0;

  int unsigned buf_idx  = 0;
  int unsigned wr_idx   = 0;
  int unsigned rd_cnt   = 0;
  int unsigned rd_run   = 0;
  int unsigned last_run = 0;

  function automatic logic [15:0] buf_word(input int unsigned i);
    logic [31:0] t;
    t = i * 32'd40503 + 32'h0000_1357;
    return t[15:0] ^ t[31:16];
  endfunction

  function automatic logic [15:0] exp_word(input int unsigned i);
    logic [31:0] t;
`ifdef FX3_TEST_PATTERN_EN
    t = i;
    return {6'b000000, t[9:0]};
`else
    t = i;
    return buf_word(t);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Buffer model: data appears the cycle after a read request.
  always @(posedge clk) begin
    if (rst) begin
      buf_idx        <= 0;
      bus.bufferData <= 16'd0;
    end else if (bus.isReading === 1'b1) begin
      bus.bufferData <= buf_word(buf_idx);
      buf_idx        <= buf_idx + 1;
    end
  end

  // Monitor: checks write order and tracks read runs.
  always @(negedge clk) begin
    if (rst) begin
      wr_idx <= 0;
      rd_cnt <= 0;
      rd_run <= 0;
    end else begin
      if (bus.fx3Write === 1'b1) begin
        check("fx3Data order", {16'd0, bus.fx3Data}, {16'd0, exp_word(wr_idx)});
        wr_idx <= wr_idx + 1;
      end
      if (bus.isReading === 1'b1) begin
        rd_cnt <= rd_cnt + 1;
        rd_run <= rd_run + 1;
      end else begin
        if (rd_run != 0) last_run <= rd_run;
        rd_run <= 0;
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        col;
    logic        dav;
    logic        rdy;
    logic        exp_rd;
    logic        exp_act;
    logic        exp_wr;
    logic [15:0] exp_bc;
    logic        chk_data;
  } vec_t;

  vec_t vecs[10];

  task automatic wait_bc(input logic [15:0] target, input string name);
    int n;
    n = 0;
    while (bus.blockCount !== target && n < 12000) begin
      tick();
      n++;
    end
    check(name, {16'd0, bus.blockCount}, {16'd0, target});
  endtask

  task automatic wait_rd(input int unsigned target, input string name);
    int n;
    n = 0;
    while (rd_cnt < target && n < 12000) begin
      tick();
      n++;
    end
    check(name, {31'd0, rd_cnt >= target}, 32'd1);
  endtask

  initial begin
    int unsigned w0;
    int unsigned r0;
    int unsigned rsnap;

    //         rst   col   dav   rdy   rd    act   wr    bc     data
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1};

    for (int i = 0; i < 10; i++) begin
      rst               = vecs[i].rst;
      bus.collectData   = vecs[i].col;
      bus.dataAvailable = vecs[i].dav;
      bus.fx3Ready      = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d isReading", i), {31'd0, bus.isReading}, {31'd0, vecs[i].exp_rd});
      check($sformatf("vec%0d transferActive", i), {31'd0, bus.transferActive}, {31'd0, vecs[i].exp_act});
      check($sformatf("vec%0d fx3Write", i), {31'd0, bus.fx3Write}, {31'd0, vecs[i].exp_wr});
      check($sformatf("vec%0d blockCount", i), {16'd0, bus.blockCount}, {16'd0, vecs[i].exp_bc});
      if (vecs[i].chk_data) check($sformatf("vec%0d fx3Data", i), {16'd0, bus.fx3Data}, 32'd0);
    end

    // Full block with fx3Ready high: latency and count.
    rst = 1'b0; bus.collectData = 1'b1; bus.dataAvailable = 1'b0; bus.fx3Ready = 1'b1;
    tick();
    tick();
    bus.dataAvailable = 1'b1;
    tick();
    check("t+1 isReading", {31'd0, bus.isReading}, 32'd1);
    check("t+1 fx3Write", {31'd0, bus.fx3Write}, 32'd0);
    tick();
    check("t+2 fx3Write", {31'd0, bus.fx3Write}, 32'd0);
    tick();
    check("t+3 fx3Write", {31'd0, bus.fx3Write}, 32'd1);
    check("t+3 fx3Data", {16'd0, bus.fx3Data}, {16'd0, exp_word(0)});
    wait_bc(16'd1, "block1 blockCount");
    check("block1 read run", last_run, BW);
    check("block1 writes", wr_idx, BW);
    check("block1 reads", rd_cnt, BW);

    // Stale dataAvailable must not start another block.
    for (int i = 0; i < 20; i++) tick();
    check("stale reads", rd_cnt, BW);
    check("stale blockCount", {16'd0, bus.blockCount}, 32'd1);
    check("stale transferActive", {31'd0, bus.transferActive}, 32'd0);
    bus.dataAvailable = 1'b0;
    tick();
    tick();
    check("rearm transferActive", {31'd0, bus.transferActive}, 32'd1);
    check("rearm isReading", {31'd0, bus.isReading}, 32'd0);

    // Block 2 with a 10-cycle back-pressure pause after read 100.
    bus.dataAvailable = 1'b1;
    wait_rd(BW + 100, "block2 reach read 100");
    bus.fx3Ready = 1'b0;
    #1;
    check("pause isReading same cycle", {31'd0, bus.isReading}, 32'd0);
    w0 = wr_idx;
    r0 = rd_cnt;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus.isReading !== 1'b0) check("pause isReading", {31'd0, bus.isReading}, 32'd0);
    end
    tick();
    check("pause extra writes", {31'd0, (wr_idx - w0) <= 2}, 32'd1);
    check("pause reads frozen", rd_cnt, r0);
    bus.fx3Ready = 1'b1;
    #1;
    check("resume isReading", {31'd0, bus.isReading}, 32'd1);
    wait_bc(16'd2, "block2 blockCount");
    check("block2 writes", wr_idx, 2 * BW);
    check("block2 reads", rd_cnt, 2 * BW);

    // Block 3: collectData dropped mid-stream still completes the block.
    bus.dataAvailable = 1'b0;
    tick();
    tick();
    bus.dataAvailable = 1'b1;
    w0 = 2 * BW + 4000;
    for (int n = 0; n < 12000 && wr_idx < w0; n++) tick();
    check("block3 reach word 4000", {31'd0, wr_idx >= w0}, 32'd1);
    bus.collectData = 1'b0;
    wait_bc(16'd3, "block3 blockCount");
    check("block3 writes", wr_idx, 3 * BW);
    for (int i = 0; i < 5; i++) tick();
    check("block3 release idle", {31'd0, bus.transferActive}, 32'd0);
    bus.dataAvailable = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus.dataAvailable = 1'b1;
    rsnap = rd_cnt;
    for (int i = 0; i < 20; i++) tick();
    check("idle no reads", rd_cnt, rsnap);
    check("idle transferActive", {31'd0, bus.transferActive}, 32'd0);

    // Block 4: reset at word 4000 abandons the block.
    bus.collectData = 1'b1;
    bus.dataAvailable = 1'b1;
    wait_rd(3 * BW + 4000, "block4 reach read 4000");
    rst = 1'b1;
    tick();
    check("reset isReading", {31'd0, bus.isReading}, 32'd0);
    check("reset fx3Write", {31'd0, bus.fx3Write}, 32'd0);
    check("reset transferActive", {31'd0, bus.transferActive}, 32'd0);
    check("reset blockCount", {16'd0, bus.blockCount}, 32'd0);
    check("reset fx3Data", {16'd0, bus.fx3Data}, 32'd0);
    tick();
    rst = 1'b0;
    bus.collectData = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("post-reset idle", {31'd0, bus.transferActive}, 32'd0);
    check("post-reset isReading", {31'd0, bus.isReading}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
